// File: rtl/pic_ack_ctrl.sv
// pic_ack_ctrl - CPU-side interrupt acknowledge sequencer for the PIC.
//
// Raises the CPU interrupt when the PIC asserts int_in and the CPU has
// interrupts enabled. It then runs the acknowledge pulse to the PIC and
// reads the PIC ISR over the register bus. The ISR is priority-encoded
// (bit 0 highest) into an 8-bit vector for the CPU. On end-of-interrupt
// the serviced ISR bit is written back cleared.
//
// Optional feature: define PIC_ACK_TIMEOUT_EN to abandon a request that
// the CPU has not acknowledged within TIMEOUT_CYCLES REQ cycles.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   int_in        PIC int output
//   intack        acknowledge pulse to PIC (INTACK_CYCLES long)
//   pic_sel       PIC register select (00 OCR, 01 IMR, 10 IRR, 11 ISR)
//   pic_rw        1 = read, 0 = write
//   pic_oe        pic_wdata drives the PIC data bus
//   pic_wdata     write data to PIC
//   pic_rdata     read data from PIC
//   cpu_ie        CPU interrupt enable (sampled in IDLE only)
//   cpu_irq       interrupt request to CPU
//   cpu_ack       CPU acknowledge pulse
//   vector        interrupt vector, {VECTOR_BASE[7:3], idx}
//   vector_valid  vector is valid until vector_taken
//   vector_taken  CPU consumed the vector
//   eoi           CPU end-of-interrupt pulse
//   spurious      current vector is spurious (ISR read as zero)
//   busy          sequencer is not idle
//   timeout       1-cycle pulse when a request times out
module pic_ack_ctrl #(
    parameter logic [7:0]  VECTOR_BASE    = 8'h20,
    parameter int unsigned INTACK_CYCLES  = 2,
    parameter int unsigned RD_WAIT        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       int_in,
    output logic       intack,
    output logic [1:0] pic_sel,
    output logic       pic_rw,
    output logic       pic_oe,
    output logic [7:0] pic_wdata,
    input  logic [7:0] pic_rdata,
    input  logic       cpu_ie,
    output logic       cpu_irq,
    input  logic       cpu_ack,
    output logic [7:0] vector,
    output logic       vector_valid,
    input  logic       vector_taken,
    input  logic       eoi,
    output logic       spurious,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_RD,
        S_VEC,
        S_SVC,
        S_WR
    } state_t;

    state_t     state;
    logic [3:0] cnt;       // shared by ACK and RD phases
    logic [7:0] isr_snap;
    logic [2:0] isr_idx;

    // Lowest set bit of the ISR read data; none_set doubles as the
    // spurious flag and the index then defaults to 3'b111.
    logic       none_set;
    logic [2:0] low_idx;

    always_comb begin
        none_set = 1'b1;
        low_idx  = 3'b111;
        for (int unsigned i = 0; i < 8; i++) begin
            if (none_set && pic_rdata[i]) begin
                none_set = 1'b0;
                low_idx  = 3'(i);
            end
        end
    end

`ifdef PIC_ACK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] req_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            isr_snap     <= '0;
            isr_idx      <= '0;
            cpu_irq      <= 1'b0;
            intack       <= 1'b0;
            pic_sel      <= 2'b00;
            pic_rw       <= 1'b1;
            pic_oe       <= 1'b0;
            pic_wdata    <= '0;
            vector       <= '0;
            vector_valid <= 1'b0;
            spurious     <= 1'b0;
            busy         <= 1'b0;
            timeout      <= 1'b0;
`ifdef PIC_ACK_TIMEOUT_EN
            req_cnt      <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (int_in && cpu_ie) begin
                        state   <= S_REQ;
                        cpu_irq <= 1'b1;
                        busy    <= 1'b1;
                    end
                end

                S_REQ: begin
`ifdef PIC_ACK_TIMEOUT_EN
                    req_cnt <= req_cnt + 1'b1;
`endif
                    // cpu_ack has priority over a simultaneous withdrawal.
                    if (cpu_ack) begin
                        state   <= S_ACK;
                        cpu_irq <= 1'b0;
                        intack  <= 1'b1;
                        cnt     <= '0;
`ifdef PIC_ACK_TIMEOUT_EN
                        req_cnt <= '0;
`endif
                    end else if (!int_in) begin
                        state   <= S_IDLE;
                        cpu_irq <= 1'b0;
                        busy    <= 1'b0;
`ifdef PIC_ACK_TIMEOUT_EN
                        req_cnt <= '0;
                    end else if (req_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        state   <= S_IDLE;
                        cpu_irq <= 1'b0;
                        busy    <= 1'b0;
                        timeout <= 1'b1;
                        req_cnt <= '0;
`endif
                    end
                end

                S_ACK: begin
                    if (cnt == 4'(INTACK_CYCLES - 1)) begin
                        state   <= S_RD;
                        intack  <= 1'b0;
                        pic_sel <= 2'b11;
                        pic_rw  <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_RD: begin
                    if (cnt == 4'(RD_WAIT - 1)) begin
                        state        <= S_VEC;
                        pic_sel      <= 2'b00;
                        cnt          <= '0;
                        isr_snap     <= pic_rdata;
                        isr_idx      <= low_idx;
                        vector       <= {VECTOR_BASE[7:3], low_idx};
                        spurious     <= none_set;
                        vector_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_VEC: begin
                    if (vector_taken) begin
                        vector_valid <= 1'b0;
                        spurious     <= 1'b0;
                        if (spurious) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_SVC;
                        end
                    end
                end

                S_SVC: begin
                    if (eoi) begin
                        state     <= S_WR;
                        pic_sel   <= 2'b11;
                        pic_rw    <= 1'b0;
                        pic_oe    <= 1'b1;
                        pic_wdata <= isr_snap & ~(8'b1 << isr_idx);
                    end
                end

                S_WR: begin
                    state   <= S_IDLE;
                    pic_sel <= 2'b00;
                    pic_rw  <= 1'b1;
                    pic_oe  <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    state   <= S_IDLE;
                    cpu_irq <= 1'b0;
                    intack  <= 1'b0;
                    pic_sel <= 2'b00;
                    pic_rw  <= 1'b1;
                    pic_oe  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ack_ctrl.sv
// tb_pic_ack_ctrl - scoreboard bench for pic_ack_ctrl.
//
// The stimulus process drives interrupt transactions and pushes the
// expected observable episodes (cpu_irq/intack/ISR-read run lengths,
// vectors, write-backs, timeouts) into queues. A negedge monitor pops
// and compares whenever the DUT presents the matching output.
// Build with PIC_ACK_TIMEOUT_EN defined to exercise the timeout path.
module tb_pic_ack_ctrl;

    localparam logic [7:0] VB = 8'h20;
    localparam int         IC = 2;
    localparam int         RW = 1;
    localparam int         TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       int_in;
    logic       intack;
    logic [1:0] pic_sel;
    logic       pic_rw;
    logic       pic_oe;
    logic [7:0] pic_wdata;
    logic [7:0] pic_rdata;
    logic       cpu_ie;
    logic       cpu_irq;
    logic       cpu_ack;
    logic [7:0] vector;
    logic       vector_valid;
    logic       vector_taken;
    logic       eoi;
    logic       spurious;
    logic       busy;
    logic       timeout;

    pic_ack_ctrl #(
        .VECTOR_BASE   (VB),
        .INTACK_CYCLES (IC),
        .RD_WAIT       (RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .int_in      (int_in),
        .intack      (intack),
        .pic_sel     (pic_sel),
        .pic_rw      (pic_rw),
        .pic_oe      (pic_oe),
        .pic_wdata   (pic_wdata),
        .pic_rdata   (pic_rdata),
        .cpu_ie      (cpu_ie),
        .cpu_irq     (cpu_irq),
        .cpu_ack     (cpu_ack),
        .vector      (vector),
        .vector_valid(vector_valid),
        .vector_taken(vector_taken),
        .eoi         (eoi),
        .spurious    (spurious),
        .busy        (busy),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected episodes
    int         q_irq[$];
    int         q_intack[$];
    int         q_rd[$];
    logic [7:0] q_wr[$];
    logic [8:0] q_vec[$];   // {spurious, vector}
    int         q_to[$];

    // Reference: vector from the lowest set ISR bit, write-back clears it.
    task automatic model(input logic [7:0] rd, output logic [8:0] ev, output logic [7:0] wd);
        int idx;
        int base;
        base = (int'(VB) / 8) * 8;
        if (rd == 0) begin
            ev = {1'b1, 8'(base + 7)};
            wd = 8'h00;
        end else begin
            idx = 0;
            while (((int'(rd) >> idx) % 2) == 0) idx++;
            ev = {1'b0, 8'(base + idx)};
            wd = 8'(int'(rd) - (1 << idx));
        end
    endtask

    // Monitor
    int irq_run = 0, ack_run = 0, rd_run = 0, wr_run = 0;
    logic prev_vv = 1'b0;

    always @(negedge clk) begin
        if (cpu_irq === 1'b1) irq_run++;
        else if (irq_run > 0) begin
            check("irq_expected", int'(q_irq.size() > 0), 1);
            if (q_irq.size() > 0) check("irq_len", irq_run, q_irq.pop_front());
            irq_run = 0;
        end

        if (intack === 1'b1) ack_run++;
        else if (ack_run > 0) begin
            check("intack_expected", int'(q_intack.size() > 0), 1);
            if (q_intack.size() > 0) check("intack_len", ack_run, q_intack.pop_front());
            ack_run = 0;
        end

        if (pic_sel === 2'b11 && pic_rw === 1'b1) rd_run++;
        else if (rd_run > 0) begin
            check("rd_expected", int'(q_rd.size() > 0), 1);
            if (q_rd.size() > 0) check("rd_len", rd_run, q_rd.pop_front());
            rd_run = 0;
        end

        if (pic_oe === 1'b1) begin
            wr_run++;
            if (wr_run == 1) begin
                check("wr_expected", int'(q_wr.size() > 0), 1);
                if (q_wr.size() > 0) check("wr_data", pic_wdata, q_wr.pop_front());
                check("wr_sel", pic_sel, 2'b11);
                check("wr_rw", pic_rw, 1'b0);
            end
        end else if (wr_run > 0) begin
            check("wr_len", wr_run, 1);
            wr_run = 0;
        end

        if (vector_valid === 1'b1 && prev_vv !== 1'b1) begin
            check("vec_expected", int'(q_vec.size() > 0), 1);
            if (q_vec.size() > 0) check("vec_spur", {spurious, vector}, q_vec.pop_front());
        end
        prev_vv = vector_valid;

        if (timeout === 1'b1) begin
            check("timeout_expected", int'(q_to.size() > 0), 1);
            if (q_to.size() > 0) void'(q_to.pop_front());
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cpu_irq"}, cpu_irq, 1'b0);
        check({tag, "_intack"}, intack, 1'b0);
        check({tag, "_pic_sel"}, pic_sel, 2'b00);
        check({tag, "_pic_rw"}, pic_rw, 1'b1);
        check({tag, "_pic_oe"}, pic_oe, 1'b0);
        check({tag, "_pic_wdata"}, pic_wdata, 8'h00);
        check({tag, "_vector"}, vector, 8'h00);
        check({tag, "_vector_valid"}, vector_valid, 1'b0);
        check({tag, "_spurious"}, spurious, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_timeout"}, timeout, 1'b0);
    endtask

    task automatic wait_irq(input string tag);
        int n;
        n = 0;
        while (cpu_irq !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check({tag, "_irq_wait"}, int'(n < 20), 1);
    endtask

    // Full interrupt transaction; ack_n = REQ cycle in which cpu_ack is high.
    task automatic txn(input logic [7:0] rd, input int ack_n, input bit drop_same,
                       input bit eoi_in_vec, input bit reset_in_rd);
        logic [8:0] ev;
        logic [7:0] wd;
        int n;
        model(rd, ev, wd);
        q_irq.push_back(ack_n);
        q_intack.push_back(IC);
        q_rd.push_back(RW);
        if (!reset_in_rd) begin
            q_vec.push_back(ev);
            if (!ev[8]) q_wr.push_back(wd);
        end
        pic_rdata = rd;
        int_in = 1'b1;
        cpu_ie = 1'b1;
        wait_irq("txn");
        tick(ack_n - 1);
        cpu_ack = 1'b1;
        if (drop_same) int_in = 1'b0;
        tick(1);
        cpu_ack = 1'b0;
        int_in = 1'b0;
        if (reset_in_rd) begin
            tick(IC);
            reset = 1'b1;
            tick(3);
            check_reset_vals("rst_rd");
            reset = 1'b0;
            tick(4);
            return;
        end
        n = 0;
        while (vector_valid !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        check("vec_wait", int'(n < 40), 1);
        if (eoi_in_vec) begin
            eoi = 1'b1;
            tick(1);
            eoi = 1'b0;
        end
        tick($urandom_range(0, 2));
        vector_taken = 1'b1;
        tick(1);
        vector_taken = 1'b0;
        if (!ev[8]) begin
            tick($urandom_range(0, 3));
            eoi = 1'b1;
            tick(1);
            eoi = 1'b0;
        end
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick(1);
            n++;
        end
        check("idle_wait", int'(n < 20), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        reset = 1'b1;
        int_in = 1'b0;
        cpu_ie = 1'b0;
        cpu_ack = 1'b0;
        pic_rdata = 8'h00;
        vector_taken = 1'b0;
        eoi = 1'b0;
        tick(3);
        check_reset_vals("por");
        reset = 1'b0;
        tick(2);

        // Directed cases
        txn(8'h14, 3, 1'b0, 1'b0, 1'b0);
        tick(2);
        txn(8'h00, 1, 1'b0, 1'b0, 1'b0);
        tick(2);

        // Withdrawn request at REQ cycle 2
        q_irq.push_back(2);
        int_in = 1'b1;
        cpu_ie = 1'b1;
        wait_irq("withdraw");
        tick(1);
        int_in = 1'b0;
        tick(3);
        check("withdraw_busy", busy, 1'b0);

        // Interrupts disabled: request ignored
        int_in = 1'b1;
        cpu_ie = 1'b0;
        tick(10);
        check("ie0_busy", busy, 1'b0);
        check("ie0_irq", cpu_irq, 1'b0);
        int_in = 1'b0;
        tick(2);

        // Ack coincident with withdrawal, eoi during VEC ignored
        txn(8'h80, 2, 1'b1, 1'b1, 1'b0);
        tick(2);

        // Reset held mid-read
        txn(8'h55, 1, 1'b0, 1'b0, 1'b1);

`ifdef PIC_ACK_TIMEOUT_EN
        q_irq.push_back(TO);
        q_irq.push_back(1);
        q_to.push_back(1);
        int_in = 1'b1;
        cpu_ie = 1'b1;
        begin
            int n;
            n = 0;
            while (timeout !== 1'b1 && n < 40) begin
                tick(1);
                n++;
            end
            check("timeout_wait", int'(n < 40), 1);
        end
        check("timeout_irq_low", cpu_irq, 1'b0);
        tick(1);
        check("timeout_reenter", cpu_irq, 1'b1);
        int_in = 1'b0;
        tick(3);
`else
        // Without the timeout feature REQ waits indefinitely
        q_irq.push_back(80);
        int_in = 1'b1;
        cpu_ie = 1'b1;
        wait_irq("long");
        tick(79);
        check("long_irq_held", cpu_irq, 1'b1);
        int_in = 1'b0;
        tick(3);
`endif

        // Randomized transactions
        for (int t = 0; t < 25; t++) begin
            rd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            txn(rd, $urandom_range(1, 5), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                eoi = 1'b1;
                tick(1);
                eoi = 1'b0;
            end
            tick($urandom_range(1, 3));
        end

        tick(5);
        check("q_irq_left", q_irq.size(), 0);
        check("q_intack_left", q_intack.size(), 0);
        check("q_rd_left", q_rd.size(), 0);
        check("q_vec_left", q_vec.size(), 0);
        check("q_wr_left", q_wr.size(), 0);
        check("q_to_left", q_to.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pic_ack_ctrl.md
Name: pic_ack_ctrl

Overview:
- Downstream CPU-side interrupt acknowledge sequencer for the PIC; consumes the PIC `int` output and drives `intack` back to it.
- Raises the CPU interrupt and runs the acknowledge handshake.
- Reads the PIC ISR over the PIC register bus, priority-encodes it into an 8-bit vector for the CPU, and writes the ISR bit back cleared on end-of-interrupt.

Parameters:
- VECTOR_BASE, 8'h20, upper 5 bits form vector[7:3]; the low 3 bits are ignored.
- INTACK_CYCLES, 2, cycles `intack` is held high (range 1..15).
- RD_WAIT, 1, cycles `pic_sel`/`pic_rw` are held for the ISR read before sampling (range 1..15).
- TIMEOUT_CYCLES, 64, REQ-state acknowledge timeout (only with PIC_ACK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- int_in  in  1  PIC `int` output
- intack  out  1  acknowledge to PIC
- pic_sel  out  2  PIC register select: 00 OCR, 01 IMR, 10 IRR, 11 ISR
- pic_rw  out  1  1 = read, 0 = write
- pic_oe  out  1  high when `pic_wdata` must drive the PIC data bus
- pic_wdata  out  8  write data to PIC
- pic_rdata  in  8  read data from PIC bus
- cpu_ie  in  1  CPU interrupt enable
- cpu_irq  out  1  interrupt request to CPU
- cpu_ack  in  1  CPU acknowledges `cpu_irq` (1-cycle pulse)
- vector  out  8  interrupt vector
- vector_valid  out  1  `vector` is valid
- vector_taken  in  1  CPU consumed the vector
- eoi  in  1  CPU end-of-interrupt pulse
- spurious  out  1  current vector is spurious
- busy  out  1  FSM not in IDLE
- timeout  out  1  1-cycle pulse on REQ timeout

Behaviour:
- Reset values (sync reset, all registered outputs):
  - cpu_irq=0, intack=0, pic_sel=00, pic_rw=1, pic_oe=0, pic_wdata=0
  - vector=0, vector_valid=0, spurious=0, busy=0, timeout=0
  - FSM=IDLE, counters=0, ISR snapshot=0
- Reset asserted in any state returns to IDLE on the next edge. No ISR write-back occurs.
- All outputs are registered. State transitions take effect on the edge after the enabling condition.
- IDLE: go to REQ when int_in=1 and cpu_ie=1. cpu_ie is sampled only in IDLE.
- REQ:
  - cpu_irq=1.
  - cpu_ack=1 -> ACK. cpu_ack wins when it coincides with int_in falling.
  - int_in=0 without cpu_ack -> IDLE (withdrawn request); cpu_irq drops.
- ACK:
  - cpu_irq=0, intack=1 for exactly INTACK_CYCLES cycles, then -> RD.
  - int_in is ignored from ACK onward.
- RD:
  - pic_sel=11, pic_rw=1 for RD_WAIT cycles.
  - On the last cycle, capture pic_rdata into the ISR snapshot, then -> VEC.
- VEC:
  - Priority: bit 0 highest.
  - idx = lowest set bit of the snapshot; vector = {VECTOR_BASE[7:3], idx}.
  - Snapshot==0: vector = {VECTOR_BASE[7:3], 3'b111}, spurious=1.
  - vector_valid=1 until vector_taken.
  - vector_taken -> SVC, or -> IDLE if spurious. vector_valid and spurious clear on that edge.
- SVC: wait for eoi; eoi -> WR. eoi outside SVC is ignored.
- WR:
  - One cycle: pic_sel=11, pic_rw=0, pic_oe=1, pic_wdata = snapshot & ~(1<<idx).
  - Then -> IDLE with pic_sel=00, pic_rw=1, pic_oe=0.
- Idle bus values: pic_sel=00, pic_rw=1, pic_oe=0.
- busy=1 in every state except IDLE.
- A new int_in arriving during SVC is not serviced until IDLE. No nesting.

Optional Feature:
- Macro PIC_ACK_TIMEOUT_EN.
- Defined:
  - A REQ-state counter increments each REQ cycle.
  - If it reaches TIMEOUT_CYCLES without cpu_ack: -> IDLE, cpu_irq=0, timeout pulses 1 cycle.
  - Counter clears on leaving REQ.
- Undefined: REQ waits indefinitely; no counter is implemented; timeout is tied 0.

Test Plan:
- Reset, then hold reset 3 cycles mid-RD -> all outputs at reset values, busy=0, no WR cycle ever seen.
- int_in=1, cpu_ie=1, cpu_ack at REQ cycle 3, pic_rdata=8'h14, defaults:
  - intack high exactly 2 cycles; pic_sel=11/pic_rw=1 for 1 cycle.
  - vector=8'h22, vector_valid=1, spurious=0.
  - After vector_taken then eoi: one WR cycle with pic_wdata=8'h10, pic_oe=1.
- pic_rdata=8'h00 during RD -> vector=8'h27, spurious=1; vector_taken -> IDLE, no WR cycle.
- int_in drops at REQ cycle 2, no cpu_ack -> cpu_irq=0 next cycle, back to IDLE, intack never asserted; cpu_ie=0 with int_in=1 -> stays IDLE.
- cpu_ack and int_in falling in the same cycle -> ACK taken; eoi pulsed during VEC -> ignored, FSM waits in SVC for a later eoi.
- With PIC_ACK_TIMEOUT_EN and TIMEOUT_CYCLES=4, no cpu_ack -> timeout pulse after 4 REQ cycles, cpu_irq=0, IDLE; re-enters REQ next cycle if int_in and cpu_ie are still high.
